// File: rtl/rf_pkg.sv
// Shared register-file types and constants, reused by writeback, the register file and decode.
package rf_pkg;
  localparam int RF_AW = 3;
  localparam int RF_DW = 8;
  localparam logic [RF_AW-1:0] RF_ZERO_REG = 3'd0;

  typedef struct packed {
    logic [RF_AW-1:0] dst;
    logic [RF_DW-1:0] data;
  } rf_wr_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// Writeback result FIFO: up to two enqueues (slot a older than slot b) and one dequeue per clock.
// The raw entry array, read pointer and valid mask are exported for the pending-write scoreboard.
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enq_a,
  input  rf_wr_t                enq_a_data,
  input  logic                  enq_b,
  input  rf_wr_t                enq_b_data,
  input  logic                  deq,
  output rf_wr_t                head,
  output logic [CW-1:0]         count,
  output logic [PW-1:0]         rd_ptr,
  output rf_wr_t [DEPTH-1:0]    entries,
  output logic [DEPTH-1:0]      valid
);

  rf_wr_t [DEPTH-1:0] mem_r;
  logic [PW-1:0]      wr_ptr_r;
  logic [PW-1:0]      rd_ptr_r;
  logic [CW-1:0]      count_r;
  logic [CW-1:0]      enq_cnt_s;
  logic [PW-1:0]      b_slot_s;
  logic               deq_s;
  logic [PW-1:0]      off_s;
  logic [DEPTH-1:0]   valid_s;

  // Enqueue count and the slot used by b (behind a when both enqueue)
  always_comb begin
    enq_cnt_s = CW'(enq_a) + CW'(enq_b);
    deq_s     = deq && (count_r != {CW{1'b0}});
    if (enq_a) begin
      b_slot_s = wr_ptr_r + PW'(1'b1);
    end else begin
      b_slot_s = wr_ptr_r;
    end
  end

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r    <= '0;
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (enq_a) mem_r[wr_ptr_r] <= enq_a_data;
      if (enq_b) mem_r[b_slot_s] <= enq_b_data;
      wr_ptr_r <= wr_ptr_r + PW'(enq_cnt_s);
      if (deq_s) rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      count_r  <= count_r + enq_cnt_s - CW'(deq_s);
    end
  end

  // An entry is live when its distance from the read pointer is below the count
  always_comb begin
    off_s   = {PW{1'b0}};
    valid_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      off_s      = PW'(i) - rd_ptr_r;
      valid_s[i] = ({1'b0, off_s} < count_r);
    end
  end

  assign head    = mem_r[rd_ptr_r];
  assign count   = count_r;
  assign rd_ptr  = rd_ptr_r;
  assign entries = mem_r;
  assign valid   = valid_s;

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Register-file writer: arbitrates ALU/load results into a FIFO, issues one write per clock,
// and exposes a pending-write scoreboard with newest-value forwarding for decode.
module rf_writeback_ctrl
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = RF_DW,
  parameter int AW    = RF_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_dst,
  input  logic [DW-1:0] alu_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_dst,
  input  logic [DW-1:0] ld_data,
  output logic [AW-1:0] D_add,
  output logic [DW-1:0] Data_in,
  output logic          write_enable,
  input  logic [AW-1:0] A_add,
  input  logic [AW-1:0] B_add,
  output logic          A_pend,
  output logic [DW-1:0] A_fwd,
  output logic          B_pend,
  output logic [DW-1:0] B_fwd,
  output logic          idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0]      count_s;
  logic [CW-1:0]      free_s;
  logic [PW-1:0]      rd_ptr_s;
  rf_wr_t             head_s;
  rf_wr_t [DEPTH-1:0] entries_s;
  logic [DEPTH-1:0]   valid_s;
  logic               alu_enq_s;
  logic               ld_enq_s;
  logic               deq_s;
  rf_wr_t             out_r;
  logic               we_r;
  logic [DW:0]        a_res_s;
  logic [DW:0]        b_res_s;

  // Newest pending value for addr: output stage first, then FIFO oldest-to-youngest so the youngest wins
  function automatic logic [DW:0] lookup(input logic [AW-1:0] addr, input logic we,
                                         input rf_wr_t outst, input rf_wr_t [DEPTH-1:0] ent,
                                         input logic [DEPTH-1:0] vld, input logic [PW-1:0] rp);
    logic [DW:0]   res;
    logic [PW-1:0] idx;
    res = {(DW+1){1'b0}};
    if (we && (outst.dst == addr)) res = {1'b1, outst.data};
    else                           res = res;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rp + PW'(i);
      if (vld[idx] && (ent[idx].dst == addr)) res = {1'b1, ent[idx].data};
      else                                    res = res;
    end
    if (addr == RF_ZERO_REG) res = {(DW+1){1'b0}};
    else                     res = res;
    return res;
  endfunction

  // Ready depends only on registered occupancy (and alu_valid for the last-slot tie-break)
  always_comb begin
    free_s    = CW'(DEPTH) - count_s;
    alu_ready = (free_s >= CW'(1'b1));
    ld_ready  = (free_s >= CW'(2'd2)) || ((free_s == CW'(1'b1)) && !alu_valid);
    alu_enq_s = alu_valid && alu_ready && (alu_dst != RF_ZERO_REG);
    ld_enq_s  = ld_valid && ld_ready && (ld_dst != RF_ZERO_REG);
    deq_s     = (count_s != {CW{1'b0}});
  end

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .enq_a      (alu_enq_s),
    .enq_a_data ('{dst: alu_dst, data: alu_data}),
    .enq_b      (ld_enq_s),
    .enq_b_data ('{dst: ld_dst, data: ld_data}),
    .deq        (deq_s),
    .head       (head_s),
    .count      (count_s),
    .rd_ptr     (rd_ptr_s),
    .entries    (entries_s),
    .valid      (valid_s)
  );

  // Output stage: the FIFO head is held for exactly one write cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r  <= 1'b0;
      out_r <= '0;
    end else if (deq_s) begin
      we_r  <= 1'b1;
      out_r <= head_s;
    end else begin
      we_r  <= 1'b0;
    end
  end

  assign a_res_s = lookup(A_add, we_r, out_r, entries_s, valid_s, rd_ptr_s);
  assign b_res_s = lookup(B_add, we_r, out_r, entries_s, valid_s, rd_ptr_s);

  assign A_pend       = a_res_s[DW];
  assign A_fwd        = a_res_s[DW-1:0];
  assign B_pend       = b_res_s[DW];
  assign B_fwd        = b_res_s[DW-1:0];
  assign D_add        = out_r.dst;
  assign Data_in      = out_r.data;
  assign write_enable = we_r;
  assign idle         = (count_s == {CW{1'b0}}) && !we_r;

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Bench for rf_writeback_ctrl: queue-based reference model checked every cycle, plus directed literal pins.
module tb_rf_writeback_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alu_valid, alu_ready, ld_valid, ld_ready;
  logic [2:0] alu_dst, ld_dst, D_add, A_add, B_add;
  logic [7:0] alu_data, ld_data, Data_in, A_fwd, B_fwd;
  logic       write_enable, A_pend, B_pend, idle;

  always #5 clk = ~clk;

  rf_writeback_ctrl #(.DEPTH(4), .DW(8), .AW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dst(alu_dst), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_dst(ld_dst), .ld_data(ld_data),
    .D_add(D_add), .Data_in(Data_in), .write_enable(write_enable),
    .A_add(A_add), .B_add(B_add), .A_pend(A_pend), .A_fwd(A_fwd),
    .B_pend(B_pend), .B_fwd(B_fwd), .idle(idle)
  );

  typedef struct {
    logic [2:0] dst;
    logic [7:0] data;
  } wr_t;

  wr_t        q[$];
  bit         m_we;
  wr_t        m_out;
  logic [7:0] m_rf[8];
  logic [7:0] d_rf[8];
  int         m_writes, d_writes;
  int         checks, errors;
  logic       act_ar, act_lr;

  // Register file stand-in: samples the write port on the falling edge
  always @(negedge clk) begin
    if (write_enable === 1'b1) begin
      d_rf[D_add] = Data_in;
      d_writes++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Newest pending value: scan queue youngest-first, then the write in flight
  task automatic lookup(input logic [2:0] a, output logic p, output logic [7:0] d);
    bit found;
    p = 1'b0; d = 8'h00; found = 0;
    if (a != 3'd0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (!found && q[i].dst == a) begin
          p = 1'b1; d = q[i].data; found = 1;
        end
      end
      if (!found && m_we && m_out.dst == a) begin
        p = 1'b1; d = m_out.data;
      end
    end
  endtask

  task automatic step(input logic av, input logic [2:0] ad, input logic [7:0] adat,
                      input logic lv, input logic [2:0] ldd, input logic [7:0] ldat,
                      input logic [2:0] aa, input logic [2:0] ba);
    int         fr;
    logic       ear, elr, ep;
    logic [7:0] ed;
    wr_t        w;
    alu_valid = av; alu_dst = ad; alu_data = adat;
    ld_valid  = lv; ld_dst  = ldd; ld_data = ldat;
    A_add = aa; B_add = ba;
    #1;
    fr  = 4 - q.size();
    ear = (fr >= 1);
    elr = (fr >= 2) || (fr == 1 && !av);
    act_ar = alu_ready; act_lr = ld_ready;
    chk("alu_ready", alu_ready, ear);
    chk("ld_ready", ld_ready, elr);
    chk("write_enable", write_enable, m_we);
    if (m_we) begin
      chk("D_add", D_add, m_out.dst);
      chk("Data_in", Data_in, m_out.data);
    end
    chk("idle", idle, (q.size() == 0 && !m_we));
    lookup(aa, ep, ed);
    chk("A_pend", A_pend, ep);
    chk("A_fwd", A_fwd, ed);
    lookup(ba, ep, ed);
    chk("B_pend", B_pend, ep);
    chk("B_fwd", B_fwd, ed);
    @(posedge clk);
    if (rst_n) begin
      if (q.size() > 0) begin
        m_out = q.pop_front();
        m_we  = 1;
        m_rf[m_out.dst] = m_out.data;
        m_writes++;
      end else begin
        m_we = 0;
      end
      if (av && ear && ad != 3'd0) begin w.dst = ad; w.data = adat; q.push_back(w); end
      if (lv && elr && ldd != 3'd0) begin w.dst = ldd; w.data = ldat; q.push_back(w); end
    end
    @(negedge clk);
  endtask

  task automatic idle_step(input logic [2:0] aa);
    step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, aa, aa);
  endtask

  initial begin
    checks = 0; errors = 0; m_writes = 0; d_writes = 0; m_we = 0;
    m_out.dst = 3'd0; m_out.data = 8'h00;
    for (int i = 0; i < 8; i++) begin m_rf[i] = 8'h00; d_rf[i] = 8'h00; end
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_dst = 3'd0; alu_data = 8'h00;
    ld_valid = 1'b0; ld_dst = 3'd0; ld_data = 8'h00;
    A_add = 3'd3; B_add = 3'd5;
    repeat (2) @(negedge clk);
    chk("rst_we", write_enable, 32'd0);
    chk("rst_D_add", D_add, 32'd0);
    chk("rst_Data_in", Data_in, 32'd0);
    chk("rst_idle", idle, 32'd1);
    chk("rst_A_pend", A_pend, 32'd0);
    chk("rst_A_fwd", A_fwd, 32'd0);
    rst_n = 1'b1;

    // single ALU write
    step(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00, 3'd3, 3'd0);
    chk("t1_pend_q", A_pend, 32'd1);
    chk("t1_fwd_q", A_fwd, 32'h5A);
    chk("t1_we0", write_enable, 32'd0);
    idle_step(3'd3);
    chk("t1_we1", write_enable, 32'd1);
    chk("t1_dadd", D_add, 32'd3);
    chk("t1_din", Data_in, 32'h5A);
    chk("t1_pend_out", A_pend, 32'd1);
    idle_step(3'd3);
    chk("t1_pend_done", A_pend, 32'd0);
    chk("t1_idle", idle, 32'd1);

    // simultaneous ALU + load
    step(1'b1, 3'd2, 8'h11, 1'b1, 3'd5, 8'h22, 3'd2, 3'd5);
    chk("t2_ar", act_ar, 32'd1);
    chk("t2_lr", act_lr, 32'd1);
    idle_step(3'd0);
    chk("t2_first", D_add, 32'd2);
    idle_step(3'd0);
    chk("t2_second", D_add, 32'd5);
    chk("t2_we", write_enable, 32'd1);
    idle_step(3'd0);

    // fill toward capacity, last-slot arbitration
    step(1'b1, 3'd1, 8'h31, 1'b1, 3'd2, 8'h32, 3'd0, 3'd0);
    step(1'b1, 3'd3, 8'h33, 1'b1, 3'd4, 8'h34, 3'd0, 3'd0);
    step(1'b1, 3'd5, 8'h35, 1'b1, 3'd7, 8'h37, 3'd5, 3'd7);
    chk("t3_ar_last", act_ar, 32'd1);
    chk("t3_lr_last", act_lr, 32'd0);
    step(1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 8'h37, 3'd5, 3'd7);
    chk("t3_lr_next", act_lr, 32'd1);
    repeat (5) idle_step(3'd7);

    // duplicate destination, newest forwarded
    step(1'b1, 3'd6, 8'h01, 1'b0, 3'd0, 8'h00, 3'd6, 3'd0);
    step(1'b1, 3'd6, 8'h02, 1'b0, 3'd0, 8'h00, 3'd6, 3'd0);
    chk("t4_pend", A_pend, 32'd1);
    chk("t4_fwd", A_fwd, 32'h02);
    repeat (4) idle_step(3'd6);
    chk("t4_rf6", d_rf[6], 32'h02);
    chk("t4_model_rf6", m_rf[6], 32'h02);

    // R0 write dropped
    step(1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
    chk("t5_ar", act_ar, 32'd1);
    chk("t5_idle", idle, 32'd1);
    idle_step(3'd0);
    chk("t5_we", write_enable, 32'd0);

    // reset mid-stream
    step(1'b1, 3'd1, 8'hAA, 1'b1, 3'd2, 8'hBB, 3'd2, 3'd3);
    step(1'b1, 3'd3, 8'hCC, 1'b0, 3'd0, 8'h00, 3'd2, 3'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_we", write_enable, 32'd0);
    chk("t6_idle", idle, 32'd1);
    chk("t6_apend", A_pend, 32'd0);
    chk("t6_bpend", B_pend, 32'd0);
    q.delete();
    m_we = 0;
    idle_step(3'd2);
    idle_step(3'd3);
    rst_n = 1'b1;
    repeat (3) idle_step(3'd2);
    chk("t6_idle_after", idle, 32'd1);
    chk("t6_writes", d_writes, m_writes);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 8'($urandom),
           $urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), 8'($urandom),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    repeat (6) idle_step(3'd0);
    chk("final_writes", d_writes, m_writes);
    for (int i = 0; i < 8; i++) chk($sformatf("final_rf%0d", i), d_rf[i], m_rf[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
